// File: rtl/acia_fifo_bridge_if.sv
// acia_fifo_bridge_if: CPU register bus plus the RX/TX byte streams of the
// ACIA-style FIFO bridge. The slave modport is the bridge itself; the master
// modport is the environment (CPU decode and USB CDC core) around it.
//
// Stream handshake: a byte moves on a rising clk edge exactly when its valid
// and ready are both 1 at that edge. Valid never waits on ready, and the data
// stays stable while valid=1 and ready=0.
interface acia_fifo_bridge_if;
    logic       cs;
    logic       we;
    logic [1:0] rs;
    logic [7:0] din;
    logic [7:0] dout;
    logic       irq;
    logic [7:0] rx_data;
    logic       rx_val;
    logic       rx_rdy;
    logic [7:0] tx_data;
    logic       tx_val;
    logic       tx_rdy;

    modport slave (
        input  cs, we, rs, din, rx_data, rx_val, tx_rdy,
        output dout, irq, rx_rdy, tx_data, tx_val
    );

    modport master (
        output cs, we, rs, din, rx_data, rx_val, tx_rdy,
        input  dout, irq, rx_rdy, tx_data, tx_val
    );
endinterface

// File: rtl/acia_fifo_bridge.sv
// acia_fifo_bridge: ACIA-style CPU register window over an RX FIFO (stream in)
// and a TX FIFO (stream out). Registers: rs=0 status/control, rs=1 data,
// rs=2 RX count, rs=3 TX free. Optional macro ACIA_LOOPBACK_EN adds a
// control bit that routes the TX head straight back into the RX FIFO.
module acia_fifo_bridge #(
    parameter int RX_AW = 4,
    parameter int TX_AW = 4
) (
    input  logic               clk,
    input  logic               rst,
    acia_fifo_bridge_if.slave  bus
);
    localparam int RX_DEPTH = 1 << RX_AW;
    localparam int TX_DEPTH = 1 << TX_AW;
    localparam logic [RX_AW:0] RX_ONE      = (RX_AW + 1)'(1);
    localparam logic [TX_AW:0] TX_ONE      = (TX_AW + 1)'(1);
    localparam logic [TX_AW:0] TX_FULL_CNT = (TX_AW + 1)'(TX_DEPTH);

    // ---------------- reset synchroniser ----------------
    logic [1:0] rst_sync;
    logic       rst_n_i;

    // Assert asynchronously, release two clk edges after rst goes high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync <= 2'b00;
        else      rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n_i = rst_sync[1];

    // ---------------- storage and pointers ----------------
    logic [7:0]     rx_mem [RX_DEPTH];
    logic [7:0]     tx_mem [TX_DEPTH];
    logic [RX_AW:0] rx_wp, rx_rp, rx_cnt;
    logic [TX_AW:0] tx_wp, tx_rp, tx_cnt, tx_free;
    logic           rx_empty, rx_full, tx_empty, tx_full;
    logic           rx_push, rx_pop, tx_push, tx_pop;
    logic [7:0]     rx_wdata, rx_head, tx_head;
    logic           rx_rdy_i, tx_val_i;

    // ---------------- CPU-side registers ----------------
    logic       cpu_rd, cpu_wr;
    logic [7:0] dout_q, rd_mux;
    logic       irq_q, txovf, rxie, txie;
    logic       lpbk, lb_xfer;

    assign cpu_rd = bus.cs & ~bus.we;
    assign cpu_wr = bus.cs & bus.we;

`ifdef ACIA_LOOPBACK_EN
    logic lpbk_q;

    // Loopback enable bit, written with the rest of the control register.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i)                      lpbk_q <= 1'b0;
        else if (cpu_wr && bus.rs == 2'd0) lpbk_q <= bus.din[3];
    end
    assign lpbk    = lpbk_q;
    assign lb_xfer = lpbk_q & ~tx_empty & ~rx_full;
`else
    assign lpbk    = 1'b0;
    assign lb_xfer = 1'b0;
`endif

    // Extra pointer MSB separates full from empty when the index bits match.
    assign rx_cnt   = rx_wp - rx_rp;
    assign tx_cnt   = tx_wp - tx_rp;
    assign tx_free  = TX_FULL_CNT - tx_cnt;
    assign rx_empty = (rx_wp == rx_rp);
    assign tx_empty = (tx_wp == tx_rp);
    assign rx_full  = (rx_wp[RX_AW] != rx_rp[RX_AW]) &&
                      (rx_wp[RX_AW-1:0] == rx_rp[RX_AW-1:0]);
    assign tx_full  = (tx_wp[TX_AW] != tx_rp[TX_AW]) &&
                      (tx_wp[TX_AW-1:0] == tx_rp[TX_AW-1:0]);

    assign rx_head  = rx_mem[rx_rp[RX_AW-1:0]];
    assign tx_head  = tx_mem[tx_rp[TX_AW-1:0]];

    // Full/empty come from registered pointers, so a pop on a full FIFO only
    // opens a slot on the following edge.
    assign rx_rdy_i = ~rx_full & ~lpbk;
    assign tx_val_i = ~tx_empty & ~lpbk;
    assign rx_push  = (bus.rx_val & rx_rdy_i) | lb_xfer;
    assign rx_wdata = lb_xfer ? tx_head : bus.rx_data;
    assign rx_pop   = cpu_rd & (bus.rs == 2'd1) & ~rx_empty;
    assign tx_push  = cpu_wr & (bus.rs == 2'd1) & ~tx_full;
    assign tx_pop   = (tx_val_i & bus.tx_rdy) | lb_xfer;

    assign bus.rx_rdy  = rx_rdy_i;
    assign bus.tx_val  = tx_val_i;
    assign bus.tx_data = tx_head;
    assign bus.dout    = dout_q;
    assign bus.irq     = irq_q;

    // FIFO storage writes; contents are left as-is by reset.
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp[RX_AW-1:0]] <= rx_wdata;
        if (tx_push) tx_mem[tx_wp[TX_AW-1:0]] <= bus.din;
    end

    // Pointer advance; push and pop in one cycle both take effect.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_wp <= '0;
            rx_rp <= '0;
            tx_wp <= '0;
            tx_rp <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + RX_ONE;
            if (rx_pop)  rx_rp <= rx_rp + RX_ONE;
            if (tx_push) tx_wp <= tx_wp + TX_ONE;
            if (tx_pop)  tx_rp <= tx_rp + TX_ONE;
        end
    end

    // Read data selection for the register addressed by rs.
    always_comb begin
        rd_mux = 8'h00;
        case (bus.rs)
            2'd0: rd_mux = {irq_q, 3'b000, lpbk, txovf, ~tx_full, ~rx_empty};
            2'd1: rd_mux = rx_empty ? 8'h00 : rx_head;
            2'd2: rd_mux = 8'(rx_cnt);
            2'd3: rd_mux = 8'(tx_free);
            default: rd_mux = 8'h00;
        endcase
    end

    // Read latch, interrupt, overflow flag and interrupt enables.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dout_q <= 8'h00;
            irq_q  <= 1'b0;
            txovf  <= 1'b0;
            rxie   <= 1'b0;
            txie   <= 1'b0;
        end else begin
            irq_q <= (rxie & ~rx_empty) | (txie & tx_empty);
            if (cpu_rd) dout_q <= rd_mux;
            if (cpu_wr && bus.rs == 2'd1 && tx_full) begin
                txovf <= 1'b1;
            end else if (cpu_wr && bus.rs == 2'd0 && bus.din[2]) begin
                txovf <= 1'b0;
            end
            if (cpu_wr && bus.rs == 2'd0) begin
                rxie <= bus.din[0];
                txie <= bus.din[1];
            end
        end
    end
endmodule

// File: doc/acia_fifo_bridge.md
ACIA_FIFO_BRIDGE -- requirements
Module: acia_fifo_bridge

Interface
REQ-001 SHALL have parameter RX_AW, default 4, meaning RX FIFO depth = 2**RX_AW bytes (legal range 1..7).
REQ-002 SHALL have parameter TX_AW, default 4, meaning TX FIFO depth = 2**TX_AW bytes (legal range 1..7).
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 cs  input  1  chip select from CPU address decode.
REQ-006 we  input  1  write enable; write when cs=1 and we=1, read when cs=1 and we=0.
REQ-007 rs  input  2  register select: 0 status/control, 1 data, 2 RX count, 3 TX free.
REQ-008 din  input  8  CPU write data.
REQ-009 dout  output  8  registered CPU read data.
REQ-010 irq  output  1  active-high interrupt request.
REQ-011 rx_data  input  8  incoming stream byte from the USB CDC core.
REQ-012 rx_val  input  1  rx_data valid.
REQ-013 rx_rdy  output  1  block can accept rx_data.
REQ-014 tx_data  output  8  outgoing stream byte to the USB CDC core.
REQ-015 tx_val  output  1  tx_data valid.
REQ-016 tx_rdy  input  1  USB CDC core accepts tx_data.

Function
REQ-017 RX push SHALL occur on any edge where rx_val=1 and rx_rdy=1; rx_rdy SHALL equal RX FIFO not full.
REQ-018 TX pop SHALL occur on any edge where tx_val=1 and tx_rdy=1; tx_val SHALL equal TX FIFO not empty; tx_data SHALL show the TX head (first-word-fall-through), stable while tx_val=1 and tx_rdy=0.
REQ-019 CPU read SHALL load dout on the edge after cs=1, we=0; dout SHALL hold its value otherwise (one-cycle latency).
REQ-020 Status read SHALL return {irq, 3'b0, lpbk, txovf, tx_not_full, rx_not_empty} in bits 7..0.
REQ-021 Data read with RX non-empty SHALL return the RX head and pop it on the same edge; with RX empty SHALL return 8'h00 with no pointer change.
REQ-022 Data write with TX not full SHALL push din; with TX full SHALL discard din and set sticky txovf.
REQ-023 RX count read SHALL return the zero-extended RX occupancy (0..2**RX_AW); TX free read SHALL return the zero-extended TX free slots (0..2**TX_AW).
REQ-024 Control write (rs=0) SHALL set rxie=din[0], txie=din[1], lpbk=din[3]; din[2]=1 SHALL clear txovf.
REQ-025 Writes to rs=2 or rs=3 SHALL be ignored.
REQ-026 irq SHALL be registered and equal (rxie AND rx_not_empty) OR (txie AND TX empty), updated every cycle.
REQ-027 Simultaneous push and pop on one FIFO in one cycle SHALL both take effect, occupancy unchanged; on a full FIFO the pop frees a slot for the following cycle only (no same-cycle bypass).
REQ-028 Pointers SHALL wrap modulo depth; full/empty SHALL be distinguished by an extra pointer MSB.
REQ-029 Occupancy counters SHALL be RX_AW+1 and TX_AW+1 bits wide; no arithmetic overflow is permitted at any legal depth.

Reset
REQ-030 On rst=0, SHALL asynchronously clear both FIFO pointers, txovf, rxie, txie, lpbk, dout=8'h00, irq=0.
REQ-031 Consequently after reset rx_rdy=1, tx_val=0, tx_data undefined-but-stable; FIFO contents need not clear.
REQ-032 Reset asserted mid-transfer SHALL drop all buffered bytes; deassertion SHALL be synchronised so the first operation occurs no earlier than the second rising edge after release.

Configuration
REQ-033 Macro ACIA_LOOPBACK_EN defined: lpbk=1 SHALL route TX head into RX FIFO (transfer when TX non-empty and RX not full), force tx_val=0 and rx_rdy=0; lpbk=0 behaves as REQ-017/018.
REQ-034 Macro ACIA_LOOPBACK_EN undefined: lpbk SHALL be tied to 0, status bit 3 SHALL read 0, din[3] ignored, no loopback logic synthesised.

Verification
REQ-035 Reset, then read rs=0 -> dout=8'h02, irq=0, rx_rdy=1, tx_val=0.
REQ-036 Stream 16 bytes 8'h10..8'h1F on rx with rx_val=1 (RX_AW=4) -> rx_rdy drops after 16th, RX count reads 16; 16 data reads return 8'h10..8'h1F in order, a 17th returns 8'h00.
REQ-037 Write 17 bytes with tx_rdy=0 (TX_AW=4) -> TX free reads 0, status=8'h04 (txovf set, not full=0); write control 8'h04 -> txovf clears.
REQ-038 rxie=1, push one byte 8'hA5 -> irq=1 within 2 cycles; data read returns 8'hA5, irq=0 the cycle after RX empties.
REQ-039 Full RX FIFO with rx_val=1 while CPU reads data -> exactly one byte accepted the cycle after the pop, count returns to 16, no byte lost or duplicated.
REQ-040 With ACIA_LOOPBACK_EN, control 8'h08, write 8'h3C -> tx_val stays 0, RX count reads 1, data read returns 8'h3C.
